// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module      : mips_core_pkg
// Description : Shared ALU op codes, branch outcome encoding and data width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_core_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [4:0] {
        ALU_NOP       = 5'd0,
        ALU_ADD       = 5'd1,
        ALU_ADDU      = 5'd2,
        ALU_SUB       = 5'd3,
        ALU_SUBU      = 5'd4,
        ALU_AND       = 5'd5,
        ALU_OR        = 5'd6,
        ALU_XOR       = 5'd7,
        ALU_NOR       = 5'd8,
        ALU_SLT       = 5'd9,
        ALU_SLTU      = 5'd10,
        ALU_SLL       = 5'd11,
        ALU_SRL       = 5'd12,
        ALU_SRA       = 5'd13,
        ALU_SLLV      = 5'd14,
        ALU_SRLV      = 5'd15,
        ALU_SRAV      = 5'd16,
        ALU_BA        = 5'd17,
        ALU_BEQ       = 5'd18,
        ALU_BNE       = 5'd19,
        ALU_BLEZ      = 5'd20,
        ALU_BGTZ      = 5'd21,
        ALU_BGEZ      = 5'd22,
        ALU_BLTZ      = 5'd23,
        ALU_MTC0_PASS = 5'd24,
        ALU_MTC0_DONE = 5'd25,
        ALU_MTC0_FAIL = 5'd26
    } AluCtl;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Codes above the last defined op are illegal.
    function automatic logic is_illegal(input AluCtl op);
        return (op > ALU_MTC0_FAIL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU datapath and branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_core_pkg::DATA_WIDTH
) (
    input  logic [4:0]            alu_ctl,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] result,
    output BranchOutcome          outcome
);

    logic op1_neg;
    logic op1_zero;

    assign op1_neg  = op1[DATA_WIDTH-1];
    assign op1_zero = (op1 == '0);

    always_comb begin
        result  = '0;
        outcome = TAKEN;
        case (AluCtl'(alu_ctl))
            ALU_ADD, ALU_ADDU: result = op1 + op2;
            ALU_SUB, ALU_SUBU: result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_NOR:  result = ~(op1 | op2);
            ALU_SLT:  result = DATA_WIDTH'($signed(op1) < $signed(op2));
            ALU_SLTU: result = DATA_WIDTH'(op1 < op2);
            // Full-width shift amounts: oversize shifts flush to zero / sign.
            ALU_SLL:  result = op1 << op2;
            ALU_SRL:  result = op1 >> op2;
            ALU_SRA:  result = DATA_WIDTH'($signed(op1) >>> op2);
            ALU_SLLV: result = op2 << op1[4:0];
            ALU_SRLV: result = op2 >> op1[4:0];
            ALU_SRAV: result = DATA_WIDTH'($signed(op2) >>> op1[4:0]);
            ALU_BA:   outcome = TAKEN;
            ALU_BEQ:  outcome = BranchOutcome'(op1 == op2);
            ALU_BNE:  outcome = BranchOutcome'(op1 != op2);
            ALU_BLEZ: outcome = BranchOutcome'(op1_neg | op1_zero);
            ALU_BGTZ: outcome = BranchOutcome'(!op1_neg && !op1_zero);
            ALU_BGEZ: outcome = BranchOutcome'(!op1_neg);
            ALU_BLTZ: outcome = BranchOutcome'(op1_neg);
            default: begin
                result  = '0;
                outcome = TAKEN;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_modport.sv
// ============================================================================
// Module      : alu_modport
// Description : Registered EX-stage ALU; ALU_PASS_DONE_EN adds MTC0 reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_modport
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mips_core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  AluCtl                 in_alu_ctl,
    input  logic [DATA_WIDTH-1:0] in_op1,
    input  logic [DATA_WIDTH-1:0] in_op2,
    input  logic                  stall,
    input  logic                  flush,
`ifdef ALU_PASS_DONE_EN
    output logic                  pass_done_valid,
    output logic [1:0]            pass_done_code,
`endif
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_result,
    output BranchOutcome          out_branch_outcome
);

    logic [DATA_WIDTH-1:0] core_result;
    BranchOutcome          core_outcome;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .alu_ctl (in_alu_ctl),
        .op1     (in_op1),
        .op2     (in_op2),
        .result  (core_result),
        .outcome (core_outcome)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid          <= 1'b0;
            out_result         <= '0;
            out_branch_outcome <= TAKEN;
        end else if (flush) begin
            out_valid          <= 1'b0;
            out_result         <= '0;
            out_branch_outcome <= TAKEN;
        end else if (!stall) begin
            out_valid          <= in_valid;
            out_result         <= in_valid ? core_result : '0;
            out_branch_outcome <= in_valid ? core_outcome : TAKEN;
        end
    end

`ifdef ALU_PASS_DONE_EN
    logic is_mtc0;
    assign is_mtc0 = (in_alu_ctl == ALU_MTC0_PASS) || (in_alu_ctl == ALU_MTC0_DONE) ||
                     (in_alu_ctl == ALU_MTC0_FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_done_valid <= 1'b0;
            pass_done_code  <= 2'd0;
        end else if (flush) begin
            pass_done_valid <= 1'b0;
            pass_done_code  <= 2'd0;
        end else if (!stall) begin
            pass_done_valid <= in_valid && is_mtc0;
            // PASS/DONE/FAIL are consecutive codes, so the offset is the report code.
            pass_done_code  <= (in_valid && is_mtc0) ?
                               2'(in_alu_ctl - ALU_MTC0_PASS) : 2'd0;
        end
    end
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (rst_n && !flush && !stall && in_valid && is_illegal(in_alu_ctl))
            $display("alu_modport: illegal alu_ctl code %0d", in_alu_ctl);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_modport.sv
// ============================================================================
// Module      : tb_alu_modport
// Description : Self-checking bench for alu_modport (reference model + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_modport;
    import mips_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    AluCtl       in_alu_ctl = ALU_NOP;
    logic [31:0] in_op1 = '0;
    logic [31:0] in_op2 = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_result;
    BranchOutcome out_branch_outcome;
`ifdef ALU_PASS_DONE_EN
    logic        pass_done_valid;
    logic [1:0]  pass_done_code;
`endif

    int asserts = 0;
    int fails   = 0;

    // Expected register contents
    logic        e_valid;
    logic [31:0] e_result;
    logic        e_outcome;
    logic        e_pd_valid;
    logic [1:0]  e_pd_code;

    alu_modport dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_alu_ctl         (in_alu_ctl),
        .in_op1             (in_op1),
        .in_op2             (in_op2),
        .stall              (stall),
        .flush              (flush),
`ifdef ALU_PASS_DONE_EN
        .pass_done_valid    (pass_done_valid),
        .pass_done_code     (pass_done_code),
`endif
        .out_valid          (out_valid),
        .out_result         (out_result),
        .out_branch_outcome (out_branch_outcome)
    );

    always #5 clk = ~clk;

    function automatic void model(input AluCtl op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0;
        o = 1'b1;
        case (op)
            ALU_ADD, ALU_ADDU: r = 32'(a + b);
            ALU_SUB, ALU_SUBU: r = 32'(a - b);
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  r = (b >= 32) ? 32'd0 : 32'(longint'(a) * (64'd1 << b[4:0]));
            ALU_SRL:  r = (b >= 32) ? 32'd0 : 32'(longint'(a) / (64'd1 << b[4:0]));
            ALU_SRA:  r = (b >= 32) ? {32{a[31]}} : 32'(sa >>> b[4:0]);
            ALU_SLLV: r = 32'(longint'(b) * (64'd1 << a[4:0]));
            ALU_SRLV: r = 32'(longint'(b) / (64'd1 << a[4:0]));
            ALU_SRAV: r = 32'(sb >>> a[4:0]);
            ALU_BEQ:  o = (a == b);
            ALU_BNE:  o = (a != b);
            ALU_BLEZ: o = (sa <= 0);
            ALU_BGTZ: o = (sa > 0);
            ALU_BGEZ: o = (sa >= 0);
            ALU_BLTZ: o = (sa < 0);
            default:  begin r = 32'd0; o = 1'b1; end
        endcase
    endfunction

    // Advance the expected register for one edge, mirroring flush > stall > load.
    task automatic predict();
        logic [31:0] r;
        logic        o;
        logic        mt;
        model(in_alu_ctl, in_op1, in_op2, r, o);
        mt = (in_alu_ctl == ALU_MTC0_PASS) || (in_alu_ctl == ALU_MTC0_DONE) ||
             (in_alu_ctl == ALU_MTC0_FAIL);
        if (flush) begin
            e_valid = 0; e_result = 0; e_outcome = 1; e_pd_valid = 0; e_pd_code = 0;
        end else if (!stall) begin
            e_valid    = in_valid;
            e_result   = in_valid ? r : 32'd0;
            e_outcome  = in_valid ? o : 1'b1;
            e_pd_valid = in_valid && mt;
            e_pd_code  = (in_valid && mt) ? ((in_alu_ctl == ALU_MTC0_PASS) ? 2'd0 :
                         (in_alu_ctl == ALU_MTC0_DONE) ? 2'd1 : 2'd2) : 2'd0;
        end
    endtask

    task automatic step(input logic v, input AluCtl op, input logic [31:0] a,
                        input logic [31:0] b, input logic st, input logic fl);
        in_valid = v; in_alu_ctl = op; in_op1 = a; in_op2 = b; stall = st; flush = fl;
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        asserts++;
        if (out_valid !== e_valid || out_result !== e_result ||
            out_branch_outcome !== BranchOutcome'(e_outcome)) begin
            fails++;
            $display("FAIL %s: got valid=%b result=%h outcome=%b, expected valid=%b result=%h outcome=%b",
                     name, out_valid, out_result, out_branch_outcome, e_valid, e_result, e_outcome);
        end
`ifdef ALU_PASS_DONE_EN
        asserts++;
        if (pass_done_valid !== e_pd_valid || pass_done_code !== e_pd_code) begin
            fails++;
            $display("FAIL %s pass_done: got %b/%0d, expected %b/%0d", name,
                     pass_done_valid, pass_done_code, e_pd_valid, e_pd_code);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 0;
        e_valid = 0; e_result = 0; e_outcome = 1; e_pd_valid = 0; e_pd_code = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1;
        #1;
    endtask

    task automatic test_arith();
        step(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0);
        asserts++;
        if (out_result !== 32'h8000_0000 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap: got %h valid=%b, expected 80000000 valid=1", out_result, out_valid);
        end
        step(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0);
        asserts++;
        if (out_result !== 32'd1) begin
            fails++; $display("FAIL slt: got %h, expected 1", out_result);
        end
        step(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0);
        asserts++;
        if (out_result !== 32'd0) begin
            fails++; $display("FAIL sltu: got %h, expected 0", out_result);
        end
        step(1, ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 0, 0);
        asserts++;
        if (out_result !== 32'hF0F0_FF00) begin
            fails++; $display("FAIL nor: got %h, expected f0f0ff00", out_result);
        end
    endtask

    task automatic test_shift();
        step(1, ALU_SRA, 32'h8000_0000, 32'd4, 0, 0);
        asserts++;
        if (out_result !== 32'hF800_0000) begin
            fails++; $display("FAIL sra: got %h, expected f8000000", out_result);
        end
        step(1, ALU_SRLV, 32'h24, 32'h8000_0000, 0, 0);
        asserts++;
        if (out_result !== 32'h0800_0000) begin
            fails++; $display("FAIL srlv: got %h, expected 08000000", out_result);
        end
        step(1, ALU_SLL, 32'hFFFF_FFFF, 32'd32, 0, 0);
        asserts++;
        if (out_result !== 32'd0) begin
            fails++; $display("FAIL sll_big: got %h, expected 0", out_result);
        end
        step(1, ALU_SRA, 32'h8000_0001, 32'd100, 0, 0);
        asserts++;
        if (out_result !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL sra_big: got %h, expected ffffffff", out_result);
        end
    endtask

    task automatic test_branch();
        step(1, ALU_BEQ, 32'd5, 32'd5, 0, 0);
        asserts++;
        if (out_branch_outcome !== TAKEN || out_result !== 32'd0) begin
            fails++; $display("FAIL beq: got %b/%h, expected 1/0", out_branch_outcome, out_result);
        end
        step(1, ALU_BNE, 32'd5, 32'd5, 0, 0);
        asserts++;
        if (out_branch_outcome !== NOT_TAKEN || out_result !== 32'd0) begin
            fails++; $display("FAIL bne: got %b/%h, expected 0/0", out_branch_outcome, out_result);
        end
        step(1, ALU_BLTZ, 32'hFFFF_FFFF, 32'd0, 0, 0);
        asserts++;
        if (out_branch_outcome !== TAKEN) begin
            fails++; $display("FAIL bltz: got %b, expected 1", out_branch_outcome);
        end
        step(1, ALU_BGTZ, 32'd0, 32'd0, 0, 0);
        asserts++;
        if (out_branch_outcome !== NOT_TAKEN) begin
            fails++; $display("FAIL bgtz: got %b, expected 0", out_branch_outcome);
        end
        step(1, ALU_BLEZ, 32'd0, 32'd9, 0, 0);
        asserts++;
        if (out_branch_outcome !== TAKEN) begin
            fails++; $display("FAIL blez: got %b, expected 1", out_branch_outcome);
        end
    endtask

    task automatic test_stall_flush();
        step(1, ALU_ADD, 32'd2, 32'd3, 0, 0);
        step(1, ALU_SUB, 32'd100, 32'd1, 1, 0);
        asserts++;
        if (out_result !== 32'd5 || out_valid !== 1'b1) begin
            fails++; $display("FAIL stall_hold: got %h valid=%b, expected 5 valid=1", out_result, out_valid);
        end
        step(1, ALU_SUB, 32'd100, 32'd1, 1, 1);
        asserts++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_branch_outcome !== TAKEN) begin
            fails++; $display("FAIL flush: got valid=%b result=%h, expected 0/0", out_valid, out_result);
        end
        step(0, ALU_ADD, 32'd7, 32'd7, 0, 0);
        check_outputs("idle_load");
        // Reset during stall must clear immediately, not at the next edge.
        step(1, ALU_OR, 32'hA5, 32'h5A00, 0, 0);
        stall = 1;
        #2;
        rst_n = 0;
        #1;
        e_valid = 0; e_result = 0; e_outcome = 1; e_pd_valid = 0; e_pd_code = 0;
        check_outputs("async_reset_in_stall");
        @(posedge clk);
        #1;
        rst_n = 1;
        stall = 0;
    endtask

    task automatic test_illegal();
        step(1, AluCtl'(5'd29), 32'hDEAD, 32'hBEEF, 0, 0);
        asserts++;
        if (out_valid !== 1'b1 || out_result !== 32'd0 || out_branch_outcome !== TAKEN) begin
            fails++; $display("FAIL illegal: got valid=%b result=%h outcome=%b", out_valid, out_result, out_branch_outcome);
        end
    endtask

    task automatic test_pass_done();
        step(1, ALU_MTC0_DONE, 32'h1234, 32'h5678, 0, 0);
        asserts++;
        if (out_result !== 32'd0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL mtc0_result: got %h, expected 0", out_result);
        end
`ifdef ALU_PASS_DONE_EN
        asserts++;
        if (pass_done_valid !== 1'b1 || pass_done_code !== 2'd1) begin
            fails++; $display("FAIL mtc0_done: got %b/%0d, expected 1/1", pass_done_valid, pass_done_code);
        end
`endif
        step(1, ALU_ADD, 32'd1, 32'd1, 0, 0);
        check_outputs("mtc0_pulse_end");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            AluCtl op;
            op = AluCtl'(5'($urandom_range(0, 31)));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 2)) - 32'd1;
            if ($urandom_range(0, 5) == 0) b = a;
            step($urandom_range(0, 7) != 0, op, a, b,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
            check_outputs("random");
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_branch();
        test_stall_flush();
        test_illegal();
        test_pass_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

`default_nettype wire
